bundle_fetch_queue: RTL and testbench

- Registered front end of the VLIW pipeline. Owns the fetch PC and issues bundle addresses to main memory.
- Buffers returned 128-bit bundles in a small FIFO and presents the head bundle, split per slot, to the ixu1/ixu2/lsu/branch decode stages.
- Replaces the combinational PC-to-fetch path. Decouples fetch from hazard stalls and performs branch redirect/flush with a squash pulse.

---
 rtl/bundle_fetch_queue_if.sv | 31 +++
 rtl/bundle_fetch_queue.sv | 102 ++++++++++
 tb/tb_bundle_fetch_queue.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bundle_fetch_queue_if.sv
// Fetch-queue port bundle: memory fetch path, hazard/redirect controls and per-slot head bundle.
// master = fetch queue side, slave = memory/decode/branch environment.
interface bundle_fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  logic [31:0]             mem_pc_out;
  logic [127:0]            mem_bundle_in;
  logic                    stall;
  logic                    branch_taken;
  logic [31:0]             new_pc;
  logic                    bundle_valid;
  logic [31:0]             bundle_pc;
  logic [31:0]             ixu1_inst;
  logic [31:0]             ixu2_inst;
  logic [31:0]             lsu_inst;
  logic [31:0]             branch_inst;
  logic                    squash;
  logic [$clog2(DEPTH):0]  occupancy;

  modport master (
    output mem_pc_out, bundle_valid, bundle_pc, ixu1_inst, ixu2_inst, lsu_inst,
           branch_inst, squash, occupancy,
    input  mem_bundle_in, stall, branch_taken, new_pc
  );

  modport slave (
    input  mem_pc_out, bundle_valid, bundle_pc, ixu1_inst, ixu2_inst, lsu_inst,
           branch_inst, squash, occupancy,
    output mem_bundle_in, stall, branch_taken, new_pc
  );
endinterface

// File: rtl/bundle_fetch_queue.sv
// VLIW fetch front end: owns fetch PC, queues {pc, bundle} entries, head shown 1 cycle after fetch when empty.
// Stall holds the head while fetch continues until full; redirect flushes the queue and pulses squash next cycle.
module bundle_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic                  clk,
  input logic                  rst,
  bundle_fetch_queue_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0]  pc;
    logic [127:0] bundle;
  } entry_t;

  entry_t        entry_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          squash_q, squash_d;
  logic          head_vld;
  logic          full;
  logic          push;
  logic          pop;
  entry_t        head;

  always_comb begin
    head_vld = (count_q != '0);
    full     = (count_q == CW'(DEPTH));
    pop      = head_vld && !bus.stall && !bus.branch_taken;
    // A full queue can still accept a fetch when the head leaves in the same cycle.
    push     = !bus.branch_taken && (!full || pop);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    squash_d   = 1'b0;
    if (bus.branch_taken) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = {bus.new_pc[31:4], 4'h0};
      squash_d   = 1'b1;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        fetch_pc_d = fetch_pc_q + 32'd16;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      squash_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      squash_q   <= squash_d;
    end
  end

  // Storage needs no reset: nothing is visible unless count says the slot is live.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      entry_q[wr_ptr_q] <= '{pc: fetch_pc_q, bundle: bus.mem_bundle_in};
    end
  end

  assign head = entry_q[rd_ptr_q];

  assign bus.mem_pc_out   = fetch_pc_q;
  assign bus.bundle_valid = head_vld;
  assign bus.bundle_pc    = head_vld ? head.pc : 32'h0;
  assign bus.ixu1_inst    = head_vld ? head.bundle[31:0]   : NOP_INST;
  assign bus.ixu2_inst    = head_vld ? head.bundle[63:32]  : NOP_INST;
  assign bus.lsu_inst     = head_vld ? head.bundle[95:64]  : NOP_INST;
  assign bus.branch_inst  = head_vld ? head.bundle[127:96] : NOP_INST;
  assign bus.squash       = squash_q;
  assign bus.occupancy    = count_q;
endmodule

// File: tb/tb_bundle_fetch_queue.sv
// Bench for bundle_fetch_queue: hand-derived vector table plus a PC scoreboard under random stall/redirect/reset.
module tb_bundle_fetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] K1  = 32'h1111_1111;
  localparam logic [31:0] K2  = 32'h2222_2222;
  localparam logic [31:0] K3  = 32'h3333_3333;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bundle_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  bundle_fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0000_0000),
    .NOP_INST(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Memory returns a bundle whose four slots are distinct functions of the fetch PC.
  assign bus.mem_bundle_in = {bus.mem_pc_out ^ K3, bus.mem_pc_out ^ K2,
                              bus.mem_pc_out ^ K1, bus.mem_pc_out};

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_sq;

  typedef struct {
    logic        r;
    logic        s;
    logic        b;
    logic [31:0] npc;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_occ;
    logic [31:0] e_mpc;
    logic        e_sq;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl[NV];

  function automatic vec_t v(input logic r, s, b, input logic [31:0] npc,
                             input logic e_vld, input logic [31:0] e_pc, e_occ, e_mpc,
                             input logic e_sq);
    vec_t x;
    x.r = r; x.s = s; x.b = b; x.npc = npc;
    x.e_vld = e_vld; x.e_pc = e_pc; x.e_occ = e_occ; x.e_mpc = e_mpc; x.e_sq = e_sq;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic r, s, b, input logic [31:0] np);
    logic pop, push;
    if (r) begin
      m_q.delete();
      m_pc = 32'h0;
      m_sq = 1'b0;
    end else if (b) begin
      m_q.delete();
      m_pc = {np[31:4], 4'h0};
      m_sq = 1'b1;
    end else begin
      m_sq = 1'b0;
      pop  = (m_q.size() != 0) && !s;
      push = (m_q.size() < DEPTH) || pop;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd16;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic        hv;
    logic [31:0] hp;
    hv = (m_q.size() != 0);
    hp = hv ? m_q[0] : 32'h0;
    chk({tag, "_valid"}, {31'b0, bus.bundle_valid}, {31'b0, hv});
    chk({tag, "_pc"}, bus.bundle_pc, hp);
    chk({tag, "_ixu1"}, bus.ixu1_inst, hv ? hp : NOP);
    chk({tag, "_ixu2"}, bus.ixu2_inst, hv ? (hp ^ K1) : NOP);
    chk({tag, "_lsu"}, bus.lsu_inst, hv ? (hp ^ K2) : NOP);
    chk({tag, "_branch"}, bus.branch_inst, hv ? (hp ^ K3) : NOP);
    chk({tag, "_occ"}, 32'(bus.occupancy), 32'(m_q.size()));
    chk({tag, "_mempc"}, bus.mem_pc_out, m_pc);
    chk({tag, "_squash"}, {31'b0, bus.squash}, {31'b0, m_sq});
  endtask

  task automatic cycle(input logic r, s, b, input logic [31:0] np, input string tag);
    @(negedge clk);
    rst              = r;
    bus.stall        = s;
    bus.branch_taken = b;
    bus.new_pc       = np;
    model_step(r, s, b, np);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.new_pc       = 32'h0;

    //            r  s  b  new_pc          vld pc            occ mem_pc        sq
    tbl[0]  = v(1, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         0);
    tbl[1]  = v(1, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         0);
    tbl[2]  = v(0, 0, 0, 32'h0,          1, 32'h0,         1, 32'h10,        0);
    tbl[3]  = v(0, 0, 0, 32'h0,          1, 32'h10,        1, 32'h20,        0);
    tbl[4]  = v(0, 0, 0, 32'h0,          1, 32'h20,        1, 32'h30,        0);
    tbl[5]  = v(1, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         0);
    tbl[6]  = v(0, 1, 0, 32'h0,          1, 32'h0,         1, 32'h10,        0);
    tbl[7]  = v(0, 1, 0, 32'h0,          1, 32'h0,         2, 32'h20,        0);
    tbl[8]  = v(0, 1, 0, 32'h0,          1, 32'h0,         3, 32'h30,        0);
    tbl[9]  = v(0, 1, 0, 32'h0,          1, 32'h0,         4, 32'h40,        0);
    tbl[10] = v(0, 1, 0, 32'h0,          1, 32'h0,         4, 32'h40,        0);
    tbl[11] = v(0, 0, 0, 32'h0,          1, 32'h10,        4, 32'h50,        0);
    tbl[12] = v(0, 1, 1, 32'h200,        0, 32'h0,         0, 32'h200,       1);
    tbl[13] = v(0, 0, 0, 32'h0,          1, 32'h200,       1, 32'h210,       0);
    tbl[14] = v(0, 1, 0, 32'h0,          1, 32'h200,       2, 32'h220,       0);
    tbl[15] = v(0, 1, 0, 32'h0,          1, 32'h200,       3, 32'h230,       0);
    tbl[16] = v(0, 0, 1, 32'h104,        0, 32'h0,         0, 32'h100,       1);
    tbl[17] = v(0, 0, 0, 32'h0,          1, 32'h100,       1, 32'h110,       0);
    tbl[18] = v(0, 0, 1, 32'h300,        0, 32'h0,         0, 32'h300,       1);
    tbl[19] = v(0, 0, 1, 32'h40F,        0, 32'h0,         0, 32'h400,       1);
    tbl[20] = v(0, 0, 0, 32'h0,          1, 32'h400,       1, 32'h410,       0);
    tbl[21] = v(0, 0, 1, 32'hFFFF_FFF0,  0, 32'h0,         0, 32'hFFFF_FFF0, 1);
    tbl[22] = v(0, 0, 0, 32'h0,          1, 32'hFFFF_FFF0, 1, 32'h0,         0);
    tbl[23] = v(0, 0, 0, 32'h0,          1, 32'h0,         1, 32'h10,        0);
    tbl[24] = v(0, 0, 0, 32'h0,          1, 32'h10,        1, 32'h20,        0);
    tbl[25] = v(0, 0, 1, 32'h60,         0, 32'h0,         0, 32'h60,        1);
    tbl[26] = v(0, 1, 0, 32'h0,          1, 32'h60,        1, 32'h70,        0);
    tbl[27] = v(0, 1, 0, 32'h0,          1, 32'h60,        2, 32'h80,        0);
    tbl[28] = v(1, 1, 1, 32'h500,        0, 32'h0,         0, 32'h0,         0);
    tbl[29] = v(0, 0, 0, 32'h0,          1, 32'h0,         1, 32'h10,        0);

    for (int i = 0; i < NV; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      cycle(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].npc, tag);
      chk({tag, "_tbl_valid"}, {31'b0, bus.bundle_valid}, {31'b0, tbl[i].e_vld});
      chk({tag, "_tbl_pc"}, bus.bundle_pc, tbl[i].e_pc);
      chk({tag, "_tbl_ixu1"}, bus.ixu1_inst, tbl[i].e_vld ? tbl[i].e_pc : NOP);
      chk({tag, "_tbl_branch"}, bus.branch_inst, tbl[i].e_vld ? (tbl[i].e_pc ^ K3) : NOP);
      chk({tag, "_tbl_occ"}, 32'(bus.occupancy), tbl[i].e_occ);
      chk({tag, "_tbl_mempc"}, bus.mem_pc_out, tbl[i].e_mpc);
      chk({tag, "_tbl_squash"}, {31'b0, bus.squash}, {31'b0, tbl[i].e_sq});
    end

    // Random traffic against the scoreboard, biased toward stalls so the queue fills.
    for (int i = 0; i < 600; i++) begin
      logic r, s, b;
      logic [31:0] np;
      r  = ($urandom_range(0, 59) == 0);
      s  = ($urandom_range(0, 9) < 6);
      b  = ($urandom_range(0, 11) == 0);
      np = $urandom;
      cycle(r, s, b, np, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
